// File: rtl/router_pkg.sv
// Shared definitions for the 1x3 packet router datapath.
// Byte width, header field positions and the reserved address code.
package router_pkg;

    localparam int DATA_WIDTH = 8;

    // Header byte layout: {payload_len[5:0], addr[1:0]}
    localparam int ADDR_LSB = 0;
    localparam int ADDR_MSB = 1;
    localparam int LEN_LSB  = 2;
    localparam int LEN_MSB  = 7;

    // Address 2'b11 has no output port and is never latched.
    localparam logic [1:0] ADDR_INVALID = 2'b11;

    function automatic logic addr_valid(input logic [1:0] addr);
        return addr != ADDR_INVALID;
    endfunction

endpackage

// File: rtl/router_parity_chk.sv
// Running XOR parity over header/payload and the received-parity compare.
// Ports: state strobes, pktvalid, header_byte, din, parity_done in; err out.
// Optional ROUTER_REG_ERR_STICKY_EN: err holds once set, detect_add clears it.
module router_parity_chk
    import router_pkg::*;
#(
    parameter int DATA_WIDTH = router_pkg::DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  detect_add,
    input  logic                  lfd_state,
    input  logic                  ld_state,
    input  logic                  full_state,
    input  logic                  pktvalid,
    input  logic                  parity_done,
    input  logic [DATA_WIDTH-1:0] header_byte,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  err
);

    logic [DATA_WIDTH-1:0] int_parity;
    logic [DATA_WIDTH-1:0] pkt_parity;
    logic                  mismatch;

    assign mismatch = (int_parity != pkt_parity);

    // Accumulator: a new packet's decode cycle restarts it.
    always_ff @(posedge clk) begin
        if (rst) begin
            int_parity <= '0;
        end else if (detect_add) begin
            int_parity <= '0;
        end else if (lfd_state && pktvalid) begin
            int_parity <= int_parity ^ header_byte;
        end else if (ld_state && pktvalid && !full_state) begin
            int_parity <= int_parity ^ din;
        end
    end

    // The byte presented with pktvalid low is the packet's parity byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_parity <= '0;
        end else if (ld_state && !pktvalid) begin
            pkt_parity <= din;
        end
    end

`ifdef ROUTER_REG_ERR_STICKY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (detect_add) begin
            err <= 1'b0;
        end else if (parity_done && mismatch) begin
            err <= 1'b1;
        end
    end
`else
    // Re-evaluated every cycle parity_done is high, so it can fall again.
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (parity_done) begin
            err <= mismatch;
        end
    end
`endif

endmodule

// File: rtl/router_reg.sv
// Router datapath register: header latch, FIFO-full byte buffer, dout mux.
// Ports: clk, rst, FSM strobes, pktvalid, fifofull, din in;
// dout, parity_done, lowpktvalid, err out.
// Optional ROUTER_REG_ERR_STICKY_EN selects a sticky err (see parity checker).
module router_reg
    import router_pkg::*;
#(
    parameter int DATA_WIDTH = router_pkg::DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pktvalid,
    input  logic                  fifofull,
    input  logic                  rst_int_reg,
    input  logic                  detect_add,
    input  logic                  ld_state,
    input  logic                  laf_state,
    input  logic                  full_state,
    input  logic                  lfd_state,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  parity_done,
    output logic                  lowpktvalid,
    output logic                  err,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] header_byte;
    logic [DATA_WIDTH-1:0] ffs_byte;
    logic                  hdr_load;
    logic                  pd_set;

    assign hdr_load = detect_add && pktvalid
                    && addr_valid(din[ADDR_MSB:ADDR_LSB]);

    // Parity byte written out, or the buffered last byte drained after full.
    assign pd_set = (ld_state && !fifofull && !pktvalid)
                  || (laf_state && lowpktvalid && !parity_done);

    always_ff @(posedge clk) begin
        if (rst) begin
            header_byte <= '0;
        end else if (hdr_load) begin
            header_byte <= din;
        end
    end

    // Byte that arrived while the FIFO could not accept it.
    always_ff @(posedge clk) begin
        if (rst) begin
            ffs_byte <= '0;
        end else if (ld_state && fifofull) begin
            ffs_byte <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout <= '0;
        end else if (lfd_state) begin
            dout <= header_byte;
        end else if (ld_state && !fifofull) begin
            dout <= din;
        end else if (laf_state) begin
            dout <= ffs_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lowpktvalid <= 1'b0;
        end else if (rst_int_reg) begin
            lowpktvalid <= 1'b0;
        end else if (ld_state && !pktvalid) begin
            lowpktvalid <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            parity_done <= 1'b0;
        end else if (detect_add) begin
            parity_done <= 1'b0;
        end else if (pd_set) begin
            parity_done <= 1'b1;
        end
    end

    router_parity_chk #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_parity_chk (
        .clk         (clk),
        .rst         (rst),
        .detect_add  (detect_add),
        .lfd_state   (lfd_state),
        .ld_state    (ld_state),
        .full_state  (full_state),
        .pktvalid    (pktvalid),
        .parity_done (parity_done),
        .header_byte (header_byte),
        .din         (din),
        .err         (err)
    );

endmodule

// File: tb/tb_router_reg.sv
// Directed self-checking bench for router_reg.
// Covers reset, good/bad parity, FIFO-full buffering, invalid address.
module tb_router_reg;

    logic       clk;
    logic       rst;
    logic       pktvalid;
    logic       fifofull;
    logic       rst_int_reg;
    logic       detect_add;
    logic       ld_state;
    logic       laf_state;
    logic       full_state;
    logic       lfd_state;
    logic [7:0] din;
    logic       parity_done;
    logic       lowpktvalid;
    logic       err;
    logic [7:0] dout;

    int n_chk;
    int n_fail;

`ifdef ROUTER_REG_ERR_STICKY_EN
    localparam logic STICKY = 1'b1;
`else
    localparam logic STICKY = 1'b0;
`endif

    router_reg #(.DATA_WIDTH(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .pktvalid    (pktvalid),
        .fifofull    (fifofull),
        .rst_int_reg (rst_int_reg),
        .detect_add  (detect_add),
        .ld_state    (ld_state),
        .laf_state   (laf_state),
        .full_state  (full_state),
        .lfd_state   (lfd_state),
        .din         (din),
        .parity_done (parity_done),
        .lowpktvalid (lowpktvalid),
        .err         (err),
        .dout        (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Outputs are sampled and inputs changed 1 time unit after each edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sends header, lfd, payload and parity byte (optionally corrupted).
    // Leaves ld_state low and parity_done high on return.
    task automatic send_packet(input logic [7:0] hdr, input int len,
                               input logic corrupt, input logic exp_err);
        logic [7:0] par;
        logic [7:0] b;
        par = hdr;
        detect_add = 1'b1;
        pktvalid   = 1'b1;
        din        = hdr;
        tick();
        detect_add = 1'b0;
        lfd_state  = 1'b1;
        tick();
        chk("hdr_dout", dout, hdr);
        lfd_state = 1'b0;
        ld_state  = 1'b1;
        for (int i = 0; i < len; i++) begin
            b   = 8'(8'h11 * (i + 1) + 8'h03);
            par = par ^ b;
            din = b;
            tick();
            chk($sformatf("payload_dout[%0d]", i), dout, b);
        end
        pktvalid = 1'b0;
        din      = corrupt ? (par ^ 8'h01) : par;
        tick();
        chk("parity_dout", dout, corrupt ? (par ^ 8'h01) : par);
        chk("lowpktvalid_set", lowpktvalid, 1'b1);
        chk("parity_done_set", parity_done, 1'b1);
        ld_state = 1'b0;
        tick();
        chk("err_after_parity", err, exp_err);
    endtask

    initial begin
        n_chk       = 0;
        n_fail      = 0;
        rst         = 1'b1;
        pktvalid    = 1'b0;
        fifofull    = 1'b0;
        rst_int_reg = 1'b0;
        detect_add  = 1'b0;
        ld_state    = 1'b0;
        laf_state   = 1'b0;
        full_state  = 1'b0;
        lfd_state   = 1'b0;
        din         = 8'h00;
        tick();
        chk("rst_dout", dout, 8'h00);
        chk("rst_parity_done", parity_done, 1'b0);
        chk("rst_lowpktvalid", lowpktvalid, 1'b0);
        chk("rst_err", err, 1'b0);
        rst = 1'b0;

        // Good packet: header 0x3A, 14 payload bytes.
        send_packet(8'h3A, 14, 1'b0, 1'b0);
        rst_int_reg = 1'b1;
        tick();
        chk("rst_int_reg_clr", lowpktvalid, 1'b0);
        rst_int_reg = 1'b0;

        // Bad parity: header 0x16 (len 5, addr 2).
        send_packet(8'h16, 5, 1'b1, 1'b1);
        rst_int_reg = 1'b1;
        tick();
        chk("rst_int_reg_clr2", lowpktvalid, 1'b0);
        chk("err_holds", err, 1'b1);
        rst_int_reg = 1'b0;

        // Invalid address header: not latched; err per sticky option.
        detect_add = 1'b1;
        pktvalid   = 1'b1;
        din        = 8'h0F;
        tick();
        chk("detect_add_err", err, STICKY ? 1'b0 : 1'b1);
        chk("detect_add_pd_clr", parity_done, 1'b0);
        detect_add = 1'b0;
        lfd_state  = 1'b1;
        tick();
        chk("invalid_addr_prior_hdr", dout, 8'h16);
        lfd_state = 1'b0;

        // FIFO full: 0x55 arrives as the parity byte while full.
        ld_state = 1'b1;
        din      = 8'hA1;
        tick();
        chk("pre_full_dout", dout, 8'hA1);
        fifofull = 1'b1;
        pktvalid = 1'b0;
        din      = 8'h55;
        tick();
        chk("full_dout_hold", dout, 8'hA1);
        chk("full_lowpktvalid", lowpktvalid, 1'b1);
        chk("full_no_pd", parity_done, 1'b0);
        ld_state   = 1'b0;
        full_state = 1'b1;
        din        = 8'h00;
        tick();
        chk("full_state_hold", dout, 8'hA1);
        full_state = 1'b0;
        fifofull   = 1'b0;
        laf_state  = 1'b1;
        tick();
        chk("laf_dout", dout, 8'h55);
        chk("laf_pd", parity_done, 1'b1);
        laf_state = 1'b0;
        tick();
        // 0x16 ^ 0xA1 = 0xB7, received 0x55.
        chk("laf_err", err, 1'b1);

        // detect_add together with a parity_done set condition: clear wins.
        detect_add = 1'b1;
        ld_state   = 1'b1;
        din        = 8'h0F;
        tick();
        chk("clr_wins_pd", parity_done, 1'b0);
        chk("clr_wins_dout", dout, 8'h0F);
        chk("clr_wins_err", err, STICKY ? 1'b0 : 1'b1);
        detect_add = 1'b0;
        ld_state   = 1'b0;

        // Reset mid-packet.
        rst_int_reg = 1'b1;
        tick();
        rst_int_reg = 1'b0;
        detect_add  = 1'b1;
        pktvalid    = 1'b1;
        din         = 8'h3A;
        tick();
        detect_add = 1'b0;
        lfd_state  = 1'b1;
        tick();
        chk("mid_hdr", dout, 8'h3A);
        lfd_state = 1'b0;
        ld_state  = 1'b1;
        din       = 8'h11;
        pktvalid  = 1'b0;
        tick();
        chk("mid_pd", parity_done, 1'b1);
        rst      = 1'b1;
        ld_state = 1'b0;
        tick();
        chk("mid_rst_dout", dout, 8'h00);
        chk("mid_rst_pd", parity_done, 1'b0);
        chk("mid_rst_lpv", lowpktvalid, 1'b0);
        chk("mid_rst_err", err, 1'b0);
        rst       = 1'b0;
        lfd_state = 1'b1;
        tick();
        chk("mid_rst_hdr_cleared", dout, 8'h00);
        lfd_state = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/router_reg.md
Name: router_reg

Overview:
- Datapath register block of the 1x3 packet router. Sits between the input port and the FIFO-select/FIFO stage, driven by the router FSM's state strobes.
- Latches the header byte and passes header, then payload and parity bytes, to the FIFO.
- Buffers one byte while the FIFO is full.
- Accumulates running XOR parity over header and payload, and flags a mismatch against the received parity byte.

Parameters:
- DATA_WIDTH, 8, byte width of din/dout and all internal byte registers.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- pktvalid  input  1  high while header/payload bytes are presented; low on the parity byte
- fifofull  input  1  selected FIFO full
- rst_int_reg  input  1  clears lowpktvalid
- detect_add  input  1  FSM in DECODE_ADDRESS state
- ld_state  input  1  FSM in LOAD_DATA
- laf_state  input  1  FSM in LOAD_AFTER_FULL
- full_state  input  1  FSM in FIFO_FULL_STATE
- lfd_state  input  1  FSM in LOAD_FIRST_DATA
- din  input  DATA_WIDTH  packet byte; header = {payload_len[5:0], addr[1:0]}
- parity_done  output  1  parity byte captured
- lowpktvalid  output  1  pktvalid has dropped during load
- err  output  1  parity mismatch
- dout  output  DATA_WIDTH  byte to FIFO

Behaviour:
- All registers update on posedge clk. rst=1 has priority and zeroes dout, parity_done, lowpktvalid, err and all internal registers (header_byte, ffs_byte, int_parity, pkt_parity).

Header and output path:
- header_byte <= din when detect_add & pktvalid & din[1:0] != 2'b11.
- dout has priority order lfd_state, then ld_state & ~fifofull, then laf_state; otherwise it holds:
  - lfd_state: dout <= header_byte.
  - ld_state & ~fifofull: dout <= din. This includes the parity byte.
  - laf_state: dout <= ffs_byte.
- ffs_byte <= din when ld_state & fifofull. This is the byte that arrived while the FIFO was full.

lowpktvalid:
- Set to 1 when ld_state & ~pktvalid.
- rst_int_reg clears it, and the clear wins over the set.
- Otherwise holds.

parity_done:
- Cleared by detect_add.
- Set by (ld_state & ~fifofull & ~pktvalid) | (laf_state & lowpktvalid & ~parity_done).
- Otherwise holds.

Internal parity:
- int_parity cleared by detect_add.
- lfd_state & pktvalid: int_parity ^= header_byte.
- ld_state & pktvalid & ~full_state: int_parity ^= din.
- pkt_parity <= din when ld_state & ~pktvalid.

err:
- When parity_done=1: err <= (int_parity != pkt_parity), evaluated every cycle parity_done is high.
- Otherwise holds.
- Net effect: err is valid one cycle after parity_done rises.

Boundary conditions:
- Header with addr 2'b11 is not latched; header_byte keeps its old value.
- Simultaneous detect_add and a set condition: the clear wins.
- Reset mid-packet aborts everything to zero.
- Latency: header appears on dout 1 cycle after lfd_state; payload bytes pass with 1-cycle latency.

Optional Feature:
- ROUTER_REG_ERR_STICKY_EN defined: err once set stays 1 until rst or detect_add. detect_add clears it to 0.
- Undefined: behaviour exactly as above. err may fall if re-evaluated as equal and is unaffected by detect_add.

Decomposition:
- Shared package router_pkg: DATA_WIDTH, ADDR_INVALID = 2'b11, and the header field slices (addr [1:0], payload_len [7:2]).
- Optional sub-module router_parity_chk holds int_parity, pkt_parity and err. The rest stays flat.

Test Plan:
- Reset: rst=1 for 1 cycle -> dout=0, parity_done=0, lowpktvalid=0, err=0.
- Good packet: detect_add with din=8'h3A (len 14, addr 2), then lfd, then 14 payload bytes under ld_state, then parity byte = XOR of all 15 with pktvalid=0.
  - dout = 8'h3A one cycle after lfd.
  - Each payload byte appears on dout the next cycle.
  - lowpktvalid=1 and parity_done=1 after the parity byte; err=0 one cycle later.
  - rst_int_reg=1 -> lowpktvalid=0.
- Bad parity: same packet with parity byte XOR 8'h01 -> err=1 one cycle after parity_done=1.
- FIFO full: during ld_state, fifofull=1 with din=8'h55 -> dout unchanged.
  - Then laf_state -> dout=8'h55.
  - With lowpktvalid=1, parity_done=1.
- Invalid address: detect_add with din=8'h0F -> header_byte unchanged, so the following lfd outputs the prior header.
- Sticky (macro on): bad packet -> err=1; next detect_add -> err=0. With the macro off, err stays 1 through detect_add.
